// File: rtl/video_sprite_pkg.sv
// Shared constants and types for the sprite overlay block.
package video_sprite_pkg;

  localparam int unsigned SPR_DW     = 12;
  localparam int unsigned SPR_SW_LOG = 5;
  localparam int unsigned SPR_SH_LOG = 5;
  localparam int unsigned SPR_CW     = 11;
  localparam int unsigned SPR_AW     = SPR_SW_LOG + SPR_SH_LOG;

  localparam logic [1:0] SPR_REG_X0  = 2'd0;
  localparam logic [1:0] SPR_REG_Y0  = 2'd1;
  localparam logic [1:0] SPR_REG_EN  = 2'd2;
  localparam logic [1:0] SPR_REG_KEY = 2'd3;

  typedef logic [SPR_DW-1:0] rgb_t;

endpackage

// File: rtl/video_sprite_render_if.sv
// Control, pixel stream and sprite RAM read signals of the sprite overlay.
interface video_sprite_render_if
  import video_sprite_pkg::*;
#(
  parameter int unsigned AW = SPR_AW,
  parameter int unsigned DW = SPR_DW,
  parameter int unsigned CW = SPR_CW
) ();

  logic          ctrl_we;
  logic [1:0]    ctrl_addr;
  logic [15:0]   ctrl_wdata;
  logic          src_vld;
  logic [CW-1:0] src_hc;
  logic [CW-1:0] src_vc;
  logic [DW-1:0] src_rgb;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_dout;
  logic          dst_vld;
  logic [DW-1:0] dst_rgb;

  modport master (
    output ctrl_we, ctrl_addr, ctrl_wdata, src_vld, src_hc, src_vc, src_rgb, ram_dout,
    input  ram_addr_r, dst_vld, dst_rgb
  );

  modport slave (
    input  ctrl_we, ctrl_addr, ctrl_wdata, src_vld, src_hc, src_vc, src_rgb, ram_dout,
    output ram_addr_r, dst_vld, dst_rgb
  );

endinterface

// File: rtl/video_sprite_ctrl.sv
// Sprite control registers: staging bank written by software, active bank
// loaded from staging only at frame start so the sprite never tears.
module video_sprite_ctrl
  import video_sprite_pkg::*;
#(
  parameter int unsigned CW = SPR_CW,
  parameter int unsigned DW = SPR_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctrl_we,
  input  logic [1:0]    ctrl_addr,
  input  logic [15:0]   ctrl_wdata,
  input  logic          frame_start,
  output logic [CW-1:0] x0,
  output logic [CW-1:0] y0,
  output logic          en,
  output logic [DW-1:0] key
);

  logic [CW-1:0] stg_x0;
  logic [CW-1:0] stg_y0;
  logic          stg_en;
  logic [DW-1:0] stg_key;
  logic          wdata_unused;

  assign wdata_unused = ^ctrl_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_x0  <= '0;
      stg_y0  <= '0;
      stg_en  <= 1'b0;
      stg_key <= '0;
      x0      <= '0;
      y0      <= '0;
      en      <= 1'b0;
      key     <= '0;
    end else begin
      if (ctrl_we) begin
        case (ctrl_addr)
          SPR_REG_X0:  stg_x0  <= ctrl_wdata[CW-1:0];
          SPR_REG_Y0:  stg_y0  <= ctrl_wdata[CW-1:0];
          SPR_REG_EN:  stg_en  <= ctrl_wdata[0];
          default:     stg_key <= ctrl_wdata[DW-1:0];
        endcase
      end
      // Same-cycle writes land in staging only and wait for the next frame
      if (frame_start) begin
        x0  <= stg_x0;
        y0  <= stg_y0;
        en  <= stg_en;
        key <= stg_key;
      end
    end
  end

endmodule

// File: rtl/video_sprite_render.sv
// Overlays a 2^SW_LOG x 2^SH_LOG sprite with colour-key transparency onto the
// pixel stream; fixed 3-cycle latency, no backpressure.
module video_sprite_render
  import video_sprite_pkg::*;
#(
  parameter int unsigned AW     = SPR_AW,
  parameter int unsigned DW     = SPR_DW,
  parameter int unsigned SW_LOG = SPR_SW_LOG,
  parameter int unsigned SH_LOG = SPR_SH_LOG,
  parameter int unsigned CW     = SPR_CW
) (
  input logic            clk,
  input logic            rst,
  video_sprite_render_if.slave bus
);

  localparam int unsigned XW = CW + 1;

  logic [CW-1:0]     x0;
  logic [CW-1:0]     y0;
  logic              en;
  logic [DW-1:0]     key;
  logic              frame_start_c;
  logic [XW-1:0]     x_end_c;
  logic [XW-1:0]     y_end_c;
  logic              hit_c;
  logic [SW_LOG-1:0] dx_c;
  logic [SH_LOG-1:0] dy_c;

  logic              s1_vld;
  logic              s1_hit;
  logic [DW-1:0]     s1_rgb;
  logic              s2_vld;
  logic              s2_hit;
  logic [DW-1:0]     s2_rgb;

  assign frame_start_c = bus.src_vld && (bus.src_hc == '0) && (bus.src_vc == '0);

  video_sprite_ctrl #(.CW(CW), .DW(DW)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .ctrl_we     (bus.ctrl_we),
    .ctrl_addr   (bus.ctrl_addr),
    .ctrl_wdata  (bus.ctrl_wdata),
    .frame_start (frame_start_c),
    .x0          (x0),
    .y0          (y0),
    .en          (en),
    .key         (key)
  );

  // Window test: upper bound in CW+1 bits so a window past the edge clips
  always_comb begin
    x_end_c = {1'b0, x0} + (XW'(1) << SW_LOG);
    y_end_c = {1'b0, y0} + (XW'(1) << SH_LOG);
    hit_c   = en
              && (bus.src_hc >= x0) && ({1'b0, bus.src_hc} < x_end_c)
              && (bus.src_vc >= y0) && ({1'b0, bus.src_vc} < y_end_c);
    dx_c    = SW_LOG'(bus.src_hc - x0);
    dy_c    = SH_LOG'(bus.src_vc - y0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld         <= 1'b0;
      s1_hit         <= 1'b0;
      s1_rgb         <= '0;
      s2_vld         <= 1'b0;
      s2_hit         <= 1'b0;
      s2_rgb         <= '0;
      bus.ram_addr_r <= '0;
      bus.dst_vld    <= 1'b0;
      bus.dst_rgb    <= '0;
    end else begin
      s1_vld <= bus.src_vld;
      s1_hit <= hit_c && bus.src_vld;
      s1_rgb <= bus.src_rgb;
      if (hit_c) begin
        bus.ram_addr_r <= AW'({dy_c, dx_c});
      end
      // Stage 1 only delays, matching the RAM read latency
      s2_vld <= s1_vld;
      s2_hit <= s1_hit;
      s2_rgb <= s1_rgb;
      bus.dst_vld <= s2_vld;
      if (!s2_vld) begin
        bus.dst_rgb <= '0;
      end else if (s2_hit && (bus.ram_dout != key)) begin
        bus.dst_rgb <= bus.ram_dout;
      end else begin
        bus.dst_rgb <= s2_rgb;
      end
    end
  end

endmodule

// File: doc/video_sprite_render.md
Name: video_sprite_render

Overview:
- Read-side consumer of the sprite pattern RAM. It overlays a 32x32 sprite onto the incoming pixel stream of the video core.
- For each input pixel it computes whether (hc,vc) falls inside the sprite window. If so, it drives the RAM read address and replaces the pixel with the sprite colour unless that colour equals the transparency key.
- Sits between the upstream video pipeline stage and the next overlay/output stage, beside the sprite RAM instance.

Parameters:
- AW, 10, sprite RAM address width; must equal SW_LOG + SH_LOG.
- DW, 12, pixel/RGB width (4:4:4).
- SW_LOG, 5, log2 sprite width (32 px).
- SH_LOG, 5, log2 sprite height (32 px).
- CW, 11, width of hc/vc and sprite origin coordinates.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ctrl_we  input  1  control register write strobe
- ctrl_addr  input  2  0=x0, 1=y0, 2=enable, 3=key
- ctrl_wdata  input  16  write data; low CW/1/DW bits used per register
- src_vld  input  1  input pixel valid
- src_hc  input  CW  input pixel horizontal count
- src_vc  input  CW  input pixel vertical count
- src_rgb  input  DW  input pixel colour
- ram_addr_r  output  AW  sprite RAM read address
- ram_dout  input  DW  sprite RAM read data; valid 1 cycle after ram_addr_r
- dst_vld  output  1  output pixel valid
- dst_rgb  output  DW  output pixel colour

Behaviour:
- Single clock domain clk. Reset rst is synchronous and active-high; all state is cleared on the rising edge of clk while rst=1.
- Reset values:
  - Outputs: dst_vld=0, dst_rgb=0, ram_addr_r=0.
  - Staging registers: x0=0, y0=0, enable=0, key=0.
  - Active registers: same values as staging.
  - Pipeline valid bits: 0.
- Control write: on ctrl_we, the staging register selected by ctrl_addr takes ctrl_wdata (x0/y0 use [CW-1:0], enable uses [0], key uses [DW-1:0]).
- Frame-synchronous update: active x0/y0/enable/key load from staging on a cycle with src_vld=1, src_hc=0, src_vc=0. This prevents tearing.
  - A ctrl_we in that same cycle writes staging only; its value reaches active at the next frame start.
- Stage 0 (combinational on src, registered into s1):
  - dx = src_hc - x0 and dy = src_vc - y0, both mod 2^CW.
  - hit = enable & (src_hc >= x0) & ({1'b0,src_hc} < {1'b0,x0} + 2^SW_LOG) & the same test on vc/y0/SH_LOG.
  - The upper-bound compare is evaluated in CW+1 bits, so a window reaching past 2^CW-1 clips and does not wrap to column 0.
  - ram_addr_r = {dy[SH_LOG-1:0], dx[SW_LOG-1:0]}, registered. When hit=0, ram_addr_r holds its previous value.
  - s1_vld <= src_vld; s1_hit <= hit & src_vld; s1_rgb <= src_rgb.
- Stage 1: s2_vld <= s1_vld; s2_hit <= s1_hit; s2_rgb <= s1_rgb. This aligns with the 1-cycle RAM read.
- Stage 2 (output register):
  - dst_vld <= s2_vld.
  - dst_rgb <= (s2_hit && ram_dout != key) ? ram_dout : s2_rgb.
  - When s2_vld=0, dst_rgb <= 0.
- Total latency from src to dst is exactly 3 cycles for every pixel. The pipeline is always flowing with no backpressure; gaps in src_vld propagate as gaps in dst_vld.
- enable=0: dst_rgb equals src_rgb delayed 3 cycles; ram_addr_r is frozen.
- Reset mid-frame clears all pipeline valid bits. Pixels in flight are dropped, not emitted.

Decomposition:
- Shared package video_sprite_pkg holds:
  - Control address constants SPR_REG_X0/Y0/EN/KEY.
  - Default SW_LOG/SH_LOG/DW.
  - An rgb_t typedef of DW bits.
- One natural sub-module, video_sprite_ctrl: staging/active register bank and the frame-start load.
- The pipeline stays in the top module. The sprite RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset behaviour: hold rst 3 cycles while driving src_vld=1 -> dst_vld=0, dst_rgb=0, ram_addr_r=0 throughout, and for 3 cycles after release.
- Bypass: enable=0, stream 640 pixels of src_rgb=12'hABC -> dst equals src exactly 3 cycles later, no gaps, ram_addr_r constant.
- Window hit: x0=100, y0=50, enable=1, key=12'h000, RAM[i]=i | 12'h800, frame start, then pixels (hc=100..131, vc=50..81).
  - (hc=100, vc=50) -> ram_addr_r=0, dst_rgb=12'h800.
  - (hc=131, vc=81) -> ram_addr_r=1023, dst_rgb=12'hBFF.
  - hc=99 and hc=132 -> src_rgb passed through.
- Transparency: RAM[5]=key=12'hF0F at (hc=x0+5, vc=y0) -> dst_rgb=src_rgb. A neighbour pixel with RAM[6]=12'h123 -> 12'h123.
- Frame-sync update: write x0=200 mid-frame -> sprite stays at x0=100 for the rest of the frame and moves to 200 only after the (0,0) pixel.
- Edge clip: x0=2040 with CW=11 -> hc=2040..2047 hit, hc=0..23 of the same line do not hit.
